// File: rtl/mult_prop_checker.sv
// mult_prop_checker: per-lane forward/swapped shift-add multipliers checked for commutativity and timing.
// Define CONST_TIME_EN to disable early termination (every engine runs WIDTH iterations).
module mult_prop_checker #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LANES*WIDTH-1:0]   op_a,
  input  logic [LANES*WIDTH-1:0]   op_b,
  output logic                     busy,
  output logic                     done,
  output logic [LANES*2*WIDTH-1:0] product,
  output logic [LANES*CNT_W-1:0]   iter_cnt,
  output logic [LANES-1:0]         comm_fail,
  output logic [LANES-1:0]         timing_diff,
  output logic [LANES-1:0]         timing_leak,
  output logic                     any_fail
);
`ifdef CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int PW = 2*WIDTH;
  localparam int NE = 2*LANES;
  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;
  state_t r_state;
  // engine 2*l is lane l forward (multiplier a), engine 2*l+1 is swapped (multiplier b)
  logic [WIDTH-1:0] r_mpl [NE];
  logic [PW-1:0]    r_mcd [NE];
  logic [PW-1:0]    r_acc [NE];
  logic [CNT_W-1:0] r_cnt [NE];
  logic [CNT_W-1:0] r_step;
  logic [WIDTH-1:0] w_mpl_nxt [NE];
  logic [NE-1:0]    w_en;
  logic             w_all_zero;
  logic             w_last;
  logic [LANES-1:0] w_comm, w_tdiff, w_leak;
  always_comb begin
    w_all_zero = 1'b1;
    for (int e = 0; e < NE; e++) begin
      w_en[e] = CT | (|r_mpl[e]);
      w_mpl_nxt[e] = r_mpl[e] >> 1;
      w_all_zero = w_all_zero & ~(|w_mpl_nxt[e]);
    end
    w_last = (r_step == CNT_W'(WIDTH-1)) | (!CT & w_all_zero);
    for (int l = 0; l < LANES; l++) begin
      w_comm[l]  = r_acc[2*l] != r_acc[2*l+1];
      w_tdiff[l] = !CT && (r_cnt[2*l] != r_cnt[2*l+1]);
      w_leak[l]  = !CT && (r_cnt[2*l] != r_cnt[0]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      product     <= '0;
      iter_cnt    <= '0;
      comm_fail   <= '0;
      timing_diff <= '0;
      timing_leak <= '0;
      any_fail    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          for (int l = 0; l < LANES; l++) begin
            r_mpl[2*l]   <= op_a[l*WIDTH +: WIDTH];
            r_mcd[2*l]   <= PW'(op_b[l*WIDTH +: WIDTH]);
            r_mpl[2*l+1] <= op_b[l*WIDTH +: WIDTH];
            r_mcd[2*l+1] <= PW'(op_a[l*WIDTH +: WIDTH]);
          end
          for (int e = 0; e < NE; e++) begin
            r_acc[e] <= '0;
            r_cnt[e] <= '0;
          end
          r_step  <= '0;
          busy    <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          for (int e = 0; e < NE; e++)
            if (w_en[e]) begin
              r_acc[e] <= r_acc[e] + (r_mpl[e][0] ? r_mcd[e] : '0);
              r_mpl[e] <= w_mpl_nxt[e];
              r_mcd[e] <= r_mcd[e] << 1;
              r_cnt[e] <= r_cnt[e] + CNT_W'(1);
            end
          r_step <= r_step + CNT_W'(1);
          if (w_last) r_state <= CHECK;
        end
        CHECK: begin
          for (int l = 0; l < LANES; l++) begin
            product[l*PW +: PW]       <= r_acc[2*l];
            iter_cnt[l*CNT_W +: CNT_W] <= r_cnt[2*l];
          end
          comm_fail   <= w_comm;
          timing_diff <= w_tdiff;
          timing_leak <= w_leak;
          any_fail    <= any_fail | (|w_comm);
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_prop_checker.sv
// tb_mult_prop_checker: directed table, corner sequences and randomized runs against an arithmetic model.
module tb_mult_prop_checker;
  localparam int W = 16, L = 2, CW = $clog2(W+1);
`ifdef CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0;
  logic [L*W-1:0] op_a = '0, op_b = '0;
  logic busy, done, any_fail;
  logic [L*2*W-1:0] product;
  logic [L*CW-1:0] iter_cnt;
  logic [L-1:0] comm_fail, timing_diff, timing_leak;
  int vecs = 0, errs = 0;

  mult_prop_checker #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .iter_cnt(iter_cnt),
    .comm_fail(comm_fail), .timing_diff(timing_diff), .timing_leak(timing_leak),
    .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L*W-1:0]   a, b;
    logic [L*2*W-1:0] prod;
    logic [L*CW-1:0]  it;
    logic [L-1:0]     td, tl;
    int               k;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int msb_iters(input logic [W-1:0] x);
    int n = 0;
    for (int i = 0; i < W; i++) if (x[i]) n = i + 1;
    return n;
  endfunction

  task automatic model(input logic [L*W-1:0] a, input logic [L*W-1:0] b, output vec_t v);
    int ia, ib, i0;
    v.a = a; v.b = b; v.k = 1;
    i0 = CT ? W : msb_iters(a[W-1:0]);
    for (int l = 0; l < L; l++) begin
      ia = CT ? W : msb_iters(a[l*W +: W]);
      ib = CT ? W : msb_iters(b[l*W +: W]);
      v.prod[l*2*W +: 2*W] = (2*W)'(a[l*W +: W]) * (2*W)'(b[l*W +: W]);
      v.it[l*CW +: CW] = CW'(ia);
      v.td[l] = ia != ib;
      v.tl[l] = ia != i0;
      if (ia > v.k) v.k = ia;
      if (ib > v.k) v.k = ib;
    end
  endtask

  // start at edge 0, scramble operands, optionally pulse start during RUN; n = edges until done
  task automatic run(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input bit pulse, output int n);
    @(negedge clk);
    op_a = a; op_b = b; start = 1;
    @(posedge clk); #1;
    start = 0; op_a = $urandom; op_b = $urandom;
    chk("busy_in_run", busy, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start = pulse && n == 1;
    end while (!done && n < 64);
    start = 0;
    if (!done) begin
      vecs++; errs++;
      $display("FAIL timeout: no done within %0d edges", n);
    end
  endtask

  task automatic compare(input vec_t v, input int n);
    chk("latency", n, v.k + 1);
    chk("product", product, v.prod);
    chk("iter_cnt", iter_cnt, v.it);
    chk("comm_fail", comm_fail, 0);
    chk("timing_diff", timing_diff, v.td);
    chk("timing_leak", timing_leak, v.tl);
    chk("any_fail", any_fail, 0);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int n, seen;
    vec_t v;
    tbl[0] = '{a: 32'h0000_0003, b: 32'h0000_0005, prod: 64'h0000_0000_0000_000F,
               it: CT ? {CW'(W), CW'(W)} : {CW'(0), CW'(2)},
               td: CT ? 2'b00 : 2'b01, tl: CT ? 2'b00 : 2'b10, k: CT ? W : 3};
    tbl[1] = '{a: 32'h0001_FFFF, b: 32'h0001_FFFF, prod: 64'h0000_0001_FFFE_0001,
               it: CT ? {CW'(W), CW'(W)} : {CW'(1), CW'(16)},
               td: 2'b00, tl: CT ? 2'b00 : 2'b10, k: W};
    tbl[2] = '{a: 32'h0, b: 32'h0, prod: 64'h0,
               it: CT ? {CW'(W), CW'(W)} : {CW'(0), CW'(0)},
               td: 2'b00, tl: 2'b00, k: CT ? W : 1};
    rst = 1; start = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; start = 0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_flags", {comm_fail, timing_diff, timing_leak, any_fail}, 0);
    repeat (3) @(posedge clk); #1;
    chk("rst_start_ignored", busy, 0);
    for (int i = 0; i < 3; i++) begin
      run(tbl[i].a, tbl[i].b, 0, n);
      compare(tbl[i], n);
    end
    run(tbl[0].a, tbl[0].b, 1, n);
    compare(tbl[0], n);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; seen |= done | busy; end
    chk("no_second_run", seen, 0);
    @(negedge clk); op_a = tbl[1].a; op_b = tbl[1].b; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    seen = 0;
    repeat (24) begin @(posedge clk); #1; seen |= done; end
    chk("abort_no_done", seen, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    chk("abort_iter", iter_cnt, 0);
    for (int i = 0; i < 30; i++) begin
      logic [L*W-1:0] a, b;
      for (int l = 0; l < L; l++) begin
        a[l*W +: W] = W'($urandom & ((32'h1 << $urandom_range(0, W)) - 1));
        b[l*W +: W] = W'($urandom & ((32'h1 << $urandom_range(0, W)) - 1));
      end
      model(a, b, v);
      run(a, b, i[0], n);
      compare(v, n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
